// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM crossbar controller.
//   - command op encoding
//   - controller state enum
//   - 2-bit line drive codes {IN1,IN0}
//   - array geometry (16 rows x 16 columns)
package rram_ctrl_pkg;

    localparam int N_ROWS = 16;
    localparam int N_COLS = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_SET   = 2'd1,
        OP_RESET = 2'd2,
        OP_MAC   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PRECH,
        ST_ACT,
        ST_CAPT,
        ST_ADC,
        ST_RECOVER,
        ST_RESP
    } state_e;

    typedef logic [1:0] lc_t;

    localparam lc_t LC_GND   = 2'b00;
    localparam lc_t LC_VREAD = 2'b01;
    localparam lc_t LC_VPROG = 2'b10;
    localparam lc_t LC_VHALF = 2'b11;

    function automatic logic [N_ROWS-1:0] row_onehot(input logic [3:0] row);
        return {{(N_ROWS-1){1'b0}}, 1'b1} << row;
    endfunction

endpackage

// File: rtl/rram_line_enc.sv
// Line-code encoder: every line whose mask bit is set gets sel_code, the
// rest get unsel_code. Output is split into the macro's IN0/IN1 planes.
// Ports:
//   sel_mask   in  16  per-line select
//   sel_code   in  2   code for selected lines
//   unsel_code in  2   code for unselected lines
//   in0, in1   out 16  low / high bit of each line's code
module rram_line_enc
    import rram_ctrl_pkg::*;
(
    input  logic [N_COLS-1:0] sel_mask,
    input  lc_t               sel_code,
    input  lc_t               unsel_code,
    output logic [N_COLS-1:0] in0,
    output logic [N_COLS-1:0] in1
);

    assign in0 = (sel_mask & {N_COLS{sel_code[0]}}) | (~sel_mask & {N_COLS{unsel_code[0]}});
    assign in1 = (sel_mask & {N_COLS{sel_code[1]}}) | (~sel_mask & {N_COLS{unsel_code[1]}});

endmodule

// File: rtl/rram_array_ctrl.sv
// Command sequencer driving the rram_simu crossbar macro. Accepts READ, SET,
// RESET and MAC commands on a valid/ready port, sequences the line codes,
// enables, precharge, CSA strobe and ADC clocking, and returns one response.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_row/
//   cmd_data host command; rsp_valid/rsp_ready/rsp_data/rsp_adc0..2/rsp_err
//   response; in0_*/in1_* line codes, enable_*, pre, saen_csa, clk_en_adc to
//   the macro; csa, adc_out0..2 from the macro.
// Build option: RRAM_CTRL_VERIFY_EN adds a verify read with up to 3 retries
//   after SET/RESET; without it rsp_err is tied 0.
//
// state      | meaning
// IDLE       | ready for a command, all lines GND
// SETUP      | BL/SL driven, WL at GND
// PRECH      | bitline precharge (READ)
// ACT        | WL driven (sense window / program pulse / MAC rows)
// CAPT       | latch CSA (READ)
// ADC        | ADC phase clocking, latch results on last cycle (MAC)
// RECOVER    | everything back to GND / disabled
// RESP       | response held until accepted
module rram_array_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int PRE_CYC   = 2,
    parameter int SENSE_CYC = 3,
    parameter int PULSE_CYC = 4,
    parameter int ADC_CYC   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_row,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_adc0,
    output logic [15:0] rsp_adc1,
    output logic [15:0] rsp_adc2,
    output logic        rsp_err,
    output logic [15:0] in0_wl,
    output logic [15:0] in1_wl,
    output logic [15:0] in0_bl,
    output logic [15:0] in1_bl,
    output logic [15:0] in0_sl,
    output logic [15:0] in1_sl,
    output logic        enable_wl,
    output logic        enable_bl,
    output logic        enable_sl,
    output logic        enable_csa,
    output logic        enable_adc,
    output logic        pre,
    output logic        saen_csa,
    output logic [1:0]  clk_en_adc,
    input  logic [15:0] csa,
    input  logic [15:0] adc_out0,
    input  logic [15:0] adc_out1,
    input  logic [15:0] adc_out2
);

    localparam logic [7:0] PRE_N   = 8'(PRE_CYC);
    localparam logic [7:0] SENSE_N = 8'(SENSE_CYC);
    localparam logic [7:0] PULSE_N = 8'(PULSE_CYC);
    localparam logic [7:0] ADC_N   = 8'(ADC_CYC);

    state_e      state_q, state_d;
    op_e         op_q, eff_op;
    logic [3:0]  row_q;
    logic [15:0] data_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;

    assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready;

`ifdef RRAM_CTRL_VERIFY_EN
    logic       verify_q, verify_d;
    logic [1:0] retry_q, retry_d;
    logic       err_q, verify_pass;

    // SET must leave every masked column reading 1, RESET every masked column 0.
    assign verify_pass = (op_q == OP_SET) ? &(rsp_data | ~data_q) : ~|(rsp_data & data_q);
    // The verify pass reuses the READ sequence on the same row.
    assign eff_op  = verify_q ? OP_READ : op_q;
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_q <= 1'b0;
            retry_q  <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            verify_q <= verify_d;
            retry_q  <= retry_d;
            if (accept)
                err_q <= 1'b0;
            else if (state_q == ST_RECOVER && verify_q && state_d == ST_RESP)
                err_q <= !verify_pass;
        end
    end
`else
    assign eff_op  = op_q;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef RRAM_CTRL_VERIFY_EN
        verify_d = verify_q;
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
`ifdef RRAM_CTRL_VERIFY_EN
                    verify_d = 1'b0;
                    retry_d  = 2'd0;
`endif
                end
            end
            ST_SETUP: begin
                if (eff_op == OP_READ) begin
                    state_d = ST_PRECH;
                    cnt_d   = PRE_N;
                end else begin
                    state_d = ST_ACT;
                    cnt_d   = (eff_op == OP_MAC) ? 8'd1 : PULSE_N;
                end
            end
            ST_PRECH: begin
                if (cnt_q == 8'd1) begin
                    state_d = ST_ACT;
                    cnt_d   = SENSE_N;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACT: begin
                if (cnt_q == 8'd1) begin
                    case (eff_op)
                        OP_READ: state_d = ST_CAPT;
                        OP_MAC: begin
                            state_d = ST_ADC;
                            cnt_d   = ADC_N;
                        end
                        default: state_d = ST_RECOVER;
                    endcase
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CAPT: state_d = ST_RECOVER;
            ST_ADC: begin
                if (cnt_q == 8'd1) state_d = ST_RECOVER;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_RECOVER: begin
                state_d = ST_RESP;
`ifdef RRAM_CTRL_VERIFY_EN
                if (op_q == OP_SET || op_q == OP_RESET) begin
                    if (!verify_q) begin
                        state_d  = ST_SETUP;
                        verify_d = 1'b1;
                    end else if (!verify_pass && retry_q != 2'd3) begin
                        state_d  = ST_SETUP;
                        verify_d = 1'b0;
                        retry_d  = retry_q + 2'd1;
                    end
                end
`endif
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Macro drive derived from the current state, registered one cycle later.
    logic [15:0] wl_mask, bl_mask, sl_mask;
    lc_t         wl_sel, wl_uns, bl_sel, bl_uns, sl_sel, sl_uns;
    logic        en_wl_d, en_bl_d, en_sl_d, en_csa_d, en_adc_d, pre_d, saen_d;
    logic [1:0]  clk_en_d;
    logic [15:0] wl0, wl1, bl0, bl1, sl0, sl1;

    always_comb begin
        wl_mask = '0;  bl_mask = '0;  sl_mask = '0;
        wl_sel = LC_GND; wl_uns = LC_GND;
        bl_sel = LC_GND; bl_uns = LC_GND;
        sl_sel = LC_GND; sl_uns = LC_GND;
        en_wl_d = 1'b0; en_bl_d = 1'b0; en_sl_d = 1'b0;
        en_csa_d = 1'b0; en_adc_d = 1'b0; pre_d = 1'b0; saen_d = 1'b0;
        clk_en_d = 2'b00;

        if (state_q inside {ST_SETUP, ST_PRECH, ST_ACT, ST_CAPT, ST_ADC}) begin
            en_bl_d = 1'b1;
            en_sl_d = 1'b1;
            case (eff_op)
                OP_SET: begin
                    bl_mask = data_q; bl_sel = LC_VPROG; bl_uns = LC_VHALF;
                end
                OP_RESET: begin
                    sl_mask = data_q; sl_sel = LC_VPROG; sl_uns = LC_VHALF;
                end
                default: begin
                    bl_mask = '1; bl_sel = LC_VREAD;
                end
            endcase
        end

        // MAC keeps its rows active through the ADC conversion window.
        if (state_q inside {ST_ACT, ST_ADC}) begin
            en_wl_d = 1'b1;
            case (eff_op)
                OP_READ: begin
                    wl_mask = row_onehot(row_q); wl_sel = LC_VREAD;
                end
                OP_MAC: begin
                    wl_mask = data_q; wl_sel = LC_VREAD;
                end
                default: begin
                    wl_mask = row_onehot(row_q); wl_sel = LC_VPROG; wl_uns = LC_VHALF;
                end
            endcase
        end

        if (state_q == ST_PRECH) begin
            pre_d    = 1'b1;
            en_csa_d = 1'b1;
        end
        if (state_q == ST_ACT && eff_op == OP_READ) begin
            en_csa_d = 1'b1;
            saen_d   = (cnt_q == 8'd1);
        end
        if (state_q == ST_CAPT) en_csa_d = 1'b1;
        if (eff_op == OP_MAC && state_q inside {ST_ACT, ST_ADC}) en_adc_d = 1'b1;
        // Phase index is ADC_N - cnt_q; its parity picks 01 first, then 10.
        if (state_q == ST_ADC) clk_en_d = (ADC_N[0] ^ cnt_q[0]) ? 2'b10 : 2'b01;
    end

    rram_line_enc u_enc_wl (.sel_mask(wl_mask), .sel_code(wl_sel), .unsel_code(wl_uns), .in0(wl0), .in1(wl1));
    rram_line_enc u_enc_bl (.sel_mask(bl_mask), .sel_code(bl_sel), .unsel_code(bl_uns), .in0(bl0), .in1(bl1));
    rram_line_enc u_enc_sl (.sel_mask(sl_mask), .sel_code(sl_sel), .unsel_code(sl_uns), .in0(sl0), .in1(sl1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0_wl <= '0; in1_wl <= '0; in0_bl <= '0; in1_bl <= '0; in0_sl <= '0; in1_sl <= '0;
            enable_wl <= 1'b0; enable_bl <= 1'b0; enable_sl <= 1'b0;
            enable_csa <= 1'b0; enable_adc <= 1'b0;
            pre <= 1'b0; saen_csa <= 1'b0; clk_en_adc <= 2'b00;
        end else begin
            in0_wl <= wl0; in1_wl <= wl1; in0_bl <= bl0; in1_bl <= bl1; in0_sl <= sl0; in1_sl <= sl1;
            enable_wl <= en_wl_d; enable_bl <= en_bl_d; enable_sl <= en_sl_d;
            enable_csa <= en_csa_d; enable_adc <= en_adc_d;
            pre <= pre_d; saen_csa <= saen_d; clk_en_adc <= clk_en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            op_q      <= OP_READ;
            row_q     <= 4'd0;
            data_q    <= 16'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
            rsp_adc0  <= 16'd0;
            rsp_adc1  <= 16'd0;
            rsp_adc2  <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_q == ST_RESP) && !(rsp_valid && rsp_ready);
            if (accept) begin
                op_q     <= op_e'(cmd_op);
                row_q    <= cmd_row;
                data_q   <= cmd_data;
                rsp_data <= 16'd0;
                rsp_adc0 <= 16'd0;
                rsp_adc1 <= 16'd0;
                rsp_adc2 <= 16'd0;
            end
            // CSA is sampled at the end of the cycle in which the strobe is high.
            if (state_q == ST_CAPT) rsp_data <= csa;
            if (state_q == ST_ADC && cnt_q == 8'd1) begin
                rsp_adc0 <= adc_out0;
                rsp_adc1 <= adc_out1;
                rsp_adc2 <= adc_out2;
            end
        end
    end

endmodule

// File: tb/tb_rram_array_ctrl.sv
module tb_rram_array_ctrl;

    localparam int PRE_CYC   = 2;
    localparam int SENSE_CYC = 3;
    localparam int PULSE_CYC = 4;
    localparam int ADC_CYC   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_row = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_data, rsp_adc0, rsp_adc1, rsp_adc2;
    logic [15:0] in0_wl, in1_wl, in0_bl, in1_bl, in0_sl, in1_sl;
    logic        enable_wl, enable_bl, enable_sl, enable_csa, enable_adc, pre, saen_csa;
    logic [1:0]  clk_en_adc;
    logic [15:0] csa = '0, adc_out0 = '0, adc_out1 = '0, adc_out2 = '0;

    always #5 clk = ~clk;

    rram_array_ctrl #(.PRE_CYC(PRE_CYC), .SENSE_CYC(SENSE_CYC), .PULSE_CYC(PULSE_CYC), .ADC_CYC(ADC_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_adc0(rsp_adc0), .rsp_adc1(rsp_adc1), .rsp_adc2(rsp_adc2), .rsp_err(rsp_err),
        .in0_wl(in0_wl), .in1_wl(in1_wl), .in0_bl(in0_bl), .in1_bl(in1_bl), .in0_sl(in0_sl), .in1_sl(in1_sl),
        .enable_wl(enable_wl), .enable_bl(enable_bl), .enable_sl(enable_sl),
        .enable_csa(enable_csa), .enable_adc(enable_adc),
        .pre(pre), .saen_csa(saen_csa), .clk_en_adc(clk_en_adc),
        .csa(csa), .adc_out0(adc_out0), .adc_out1(adc_out1), .adc_out2(adc_out2)
    );

    wire [107:0] macro_out = {in0_wl, in1_wl, in0_bl, in1_bl, in0_sl, in1_sl,
                              enable_wl, enable_bl, enable_sl, enable_csa, enable_adc,
                              pre, saen_csa, clk_en_adc};
    wire [67:0]  host_out  = {cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_adc0, rsp_adc1, rsp_adc2[15:1], rsp_adc2[0]};

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  row;
        logic [15:0] data, csa, a0, a1, a2;
        int          rdy_dly;
        int          exp_lat;
        logic [15:0] exp_rsp, exp_a0, exp_a1, exp_a2;
        int          exp_wl;     // -1: WL window length not checked
        int          exp_saen;
        int          exp_adck;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    string cur_tag = "init";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_tag, nm, act, exp);
        end
    endtask

    // Reference rules for each line's drive code, straight from the op definitions.
    function automatic logic [1:0] line_code(input int which, input vec_t v, input int k);
        case (which)
            0: case (v.op)
                   2'd0:       return (k == int'(v.row)) ? 2'b01 : 2'b00;
                   2'd1, 2'd2: return (k == int'(v.row)) ? 2'b10 : 2'b11;
                   default:    return v.data[k] ? 2'b01 : 2'b00;
               endcase
            1: case (v.op)
                   2'd1:    return v.data[k] ? 2'b10 : 2'b11;
                   2'd2:    return 2'b00;
                   default: return 2'b01;
               endcase
            default: return (v.op == 2'd2) ? (v.data[k] ? 2'b10 : 2'b11) : 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] exp_lines(input int which, input vec_t v);
        logic [15:0] i0, i1;
        logic [1:0]  c;
        for (int k = 0; k < 16; k++) begin
            c = line_code(which, v, k);
            i0[k] = c[0];
            i1[k] = c[1];
        end
        return {i1, i0};
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_rsp = 16'd0; r.exp_a0 = 16'd0; r.exp_a1 = 16'd0; r.exp_a2 = 16'd0;
        r.exp_saen = 0; r.exp_adck = 0;
        case (v.op)
            2'd0: begin
                r.exp_lat = 4 + PRE_CYC + SENSE_CYC; r.exp_rsp = v.csa;
                r.exp_wl = SENSE_CYC; r.exp_saen = 1;
            end
            2'd3: begin
                r.exp_lat = 4 + ADC_CYC; r.exp_wl = -1; r.exp_adck = ADC_CYC;
                r.exp_a0 = v.a0; r.exp_a1 = v.a1; r.exp_a2 = v.a2;
            end
            default: begin
                r.exp_lat = 3 + PULSE_CYC; r.exp_wl = PULSE_CYC;
            end
        endcase
        return r;
    endfunction

    // Issues one command and follows it to an accepted response. Entered and left at a negedge.
    task automatic run_cmd(input vec_t v, output int waited);
        int cyc = 0, wl_n = 0, saen_n = 0, adck_n = 0;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_ready", cmd_ready, 1);
        if (!cmd_ready) return;
        cmd_op = v.op; cmd_row = v.row; cmd_data = v.data;
        csa = v.csa; adc_out0 = v.a0; adc_out1 = v.a1; adc_out2 = v.a2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && cyc < 300) begin
            if (enable_wl) begin
                wl_n++;
                chk("wl_codes", {in1_wl, in0_wl}, exp_lines(0, v));
            end
            if (enable_bl) chk("bl_codes", {in1_bl, in0_bl}, exp_lines(1, v));
            if (enable_sl) chk("sl_codes", {in1_sl, in0_sl}, exp_lines(2, v));
            if (saen_csa) saen_n++;
            if (clk_en_adc != 2'b00) begin
                chk("adc_clk_phase", clk_en_adc, (adck_n % 2 == 0) ? 2'b01 : 2'b10);
                adck_n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, v.exp_lat);
        if (!rsp_valid) return;
        chk("resp_lines_idle", |macro_out, 0);
        if (v.exp_wl >= 0) chk("wl_cycles", wl_n, v.exp_wl);
        chk("saen_cycles", saen_n, v.exp_saen);
        chk("adc_clk_cycles", adck_n, v.exp_adck);
        for (int i = 0; i < v.rdy_dly; i++) begin
            chk("hold", {rsp_valid, cmd_ready, rsp_data, rsp_adc0, rsp_adc1, rsp_adc2},
                {1'b1, 1'b0, v.exp_rsp, v.exp_a0, v.exp_a1, v.exp_a2});
            cmd_valid = (i == 0);
            cmd_op = 2'd3;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("rsp_data", rsp_data, v.exp_rsp);
        chk("rsp_adc", {rsp_adc0, rsp_adc1, rsp_adc2}, {v.exp_a0, v.exp_a1, v.exp_a2});
`ifndef RRAM_CTRL_VERIFY_EN
        chk("rsp_err", rsp_err, 0);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_accept", {rsp_valid, cmd_ready, |macro_out}, 3'b010);
    endtask

    vec_t tbl[7];
    vec_t v;
    int   w;

    initial begin
        //        op    row    data       csa        a0         a1         a2         dly lat rsp        a0         a1         a2         wl saen adck
        tbl[0] = '{2'd0, 4'd3,  16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 0, 9,  16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 3, 1, 0};
        tbl[1] = '{2'd1, 4'd5,  16'h0081, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 7,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 4, 0, 0};
        tbl[2] = '{2'd3, 4'd0,  16'h000F, 16'h0000, 16'h0011, 16'h0022, 16'h0033, 0, 12, 16'h0000, 16'h0011, 16'h0022, 16'h0033, -1, 0, 8};
        tbl[3] = '{2'd2, 4'd15, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 2, 7,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 4, 0, 0};
        tbl[4] = '{2'd3, 4'd7,  16'h0000, 16'h0000, 16'hBEEF, 16'h0001, 16'h8000, 0, 12, 16'h0000, 16'hBEEF, 16'h0001, 16'h8000, -1, 0, 8};
        tbl[5] = '{2'd0, 4'd0,  16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 5, 9,  16'h1234, 16'h0000, 16'h0000, 16'h0000, 3, 1, 0};
        tbl[6] = '{2'd2, 4'd9,  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 7,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 4, 0, 0};

        cur_tag = "reset";
        #3;
        chk("all_zero", |{macro_out, host_out}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            cur_tag = $sformatf("tbl%0d", i);
            run_cmd(tbl[i], w);
        end

        for (int i = 0; i < 24; i++) begin
            cur_tag = $sformatf("rnd%0d", i);
            v.op = 2'($urandom_range(0, 3));
            v.row = 4'($urandom);
            v.data = 16'($urandom);
            v.csa = 16'($urandom);
            v.a0 = 16'($urandom);
            v.a1 = 16'($urandom);
            v.a2 = 16'($urandom);
            v.rdy_dly = $urandom_range(0, 3);
            run_cmd(model(v), w);
        end

        cur_tag = "b2b";
        v = '{2'd0, 4'd6, 16'h0000, 16'h5A0F, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0};
        run_cmd(model(v), w);
        v.op = 2'd2; v.row = 4'd11; v.data = 16'hF00F;
        run_cmd(model(v), w);
        chk("second_accept_wait", w, 0);

        cur_tag = "rst_mid_act";
        cmd_op = 2'd1; cmd_row = 4'd2; cmd_data = 16'h00FF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_act", enable_wl, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_clear", |{macro_out, host_out}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("held_in_reset", {rsp_valid, cmd_ready}, 2'b00);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {cmd_ready, rsp_valid, |macro_out}, 3'b100);

        cur_tag = "post_reset";
        v = '{2'd3, 4'd0, 16'h8001, 16'h0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0};
        run_cmd(model(v), w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rram_array_ctrl.md
Name: rram_array_ctrl

Overview:
Command-driven sequencer that is the initiator for the rram_simu crossbar macro interface. It generates the WL/BL/SL line codes, enables, precharge, CSA strobe and ADC clock gating for each operation, then captures CSA or ADC results. A host issues READ, SET, RESET or MAC commands over a valid/ready port and gets one response per command.

Parameters:
PRE_CYC, 2, precharge cycles with PRE=1 (READ only); legal range 1..255
SENSE_CYC, 3, WL-active cycles before the CSA strobe (READ); legal range 1..255
PULSE_CYC, 4, WL-active programming pulse cycles (SET/RESET); legal range 1..255
ADC_CYC, 8, ADC clock cycles (MAC); legal range 1..255

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command valid
CMD_READY  out  1  controller can accept a command
CMD_OP  in  2  0=READ 1=SET 2=RESET 3=MAC
CMD_ROW  in  4  target row (READ/SET/RESET)
CMD_DATA  in  16  column mask (SET/RESET); row mask (MAC); ignored for READ
RSP_VALID  out  1  response valid
RSP_READY  in  1  host accepts response
RSP_DATA  out  16  captured CSA (READ), else 0
RSP_ADC0/RSP_ADC1/RSP_ADC2  out  16 each  captured ADC_OUT0..2 (MAC), else 0
RSP_ERR  out  1  write-verify failure (see Optional Feature)
IN0_WL/IN1_WL, IN0_BL/IN1_BL, IN0_SL/IN1_SL  out  16 each  per-line 2-bit drive code {IN1[k],IN0[k]}
ENABLE_WL/ENABLE_BL/ENABLE_SL/ENABLE_CSA/ENABLE_ADC  out  1 each  macro block enables
PRE  out  1  bitline precharge
SAEN_CSA  out  1  CSA sense strobe
CLK_EN_ADC  out  2  ADC phase clock enables
CSA  in  16  sense-amp outputs from macro
ADC_OUT0/ADC_OUT1/ADC_OUT2  in  16 each  ADC results from macro

Behaviour:
- Single clock domain, CLK rising edge; RST_N asynchronous active-low. On reset, all outputs go to 0 immediately (all lines GND, enables low, CMD_READY=0, RSP_VALID=0); IDLE on the first edge after release. Reset mid-operation aborts with no response.
- Line codes: 00 GND, 01 VREAD, 10 VPROG, 11 VHALF (inhibit). All macro outputs are registered.
- States: IDLE, SETUP, PRECH, ACT, CAPT, ADC, RECOVER, RESP.
- IDLE: CMD_READY=1 and lines at GND. On CMD_VALID&CMD_READY, register the command and go to SETUP. CMD_READY=0 in every other state.
- SETUP (1 cycle): drive BL/SL codes and ENABLE_BL/ENABLE_SL=1. WL stays GND.
  - READ: BL all 01, SL all 00.
  - SET: BL 10 where mask=1 else 11, SL 00.
  - RESET: SL 10 where mask=1 else 11, BL 00.
  - MAC: BL all 01, SL 00.
- PRECH (READ only, PRE_CYC cycles): PRE=1, ENABLE_CSA=1.
- ACT: ENABLE_WL=1.
  - READ: selected row 01, other rows 00, for SENSE_CYC cycles; SAEN_CSA=1 on the last ACT cycle only.
  - SET/RESET: selected row 10, other rows 11, for PULSE_CYC cycles.
  - MAC: rows with mask=1 get 01, others 00; ENABLE_ADC=1; go to ADC.
- CAPT (READ, 1 cycle): register CSA into RSP_DATA.
- ADC (MAC, ADC_CYC cycles): CLK_EN_ADC alternates 01,10,01,... starting at 01. ADC_OUT0..2 are registered on the final ADC cycle, and CLK_EN_ADC returns to 00.
- RECOVER (1 cycle): all codes 00, all enables, PRE and SAEN_CSA low.
- RESP: RSP_VALID=1 with data held stable until RSP_READY; then IDLE. RSP_VALID drops on the accepting edge.
- Latency from accept edge to RSP_VALID:
  - READ: 4+PRE_CYC+SENSE_CYC (9 at defaults).
  - SET/RESET: 3+PULSE_CYC.
  - MAC: 4+ADC_CYC.
- MAC with row mask 0: sequence still runs and returns captured ADC values. SET/RESET with column mask 0: all columns inhibited, response still issued.
- Phase counter is 8 bits and counts down to 1.

Optional Feature:
- Macro RRAM_CTRL_VERIFY_EN.
- Defined: after SET/RESET RECOVER, an internal READ of the same row runs. Masked columns of CSA must equal 1 for SET or 0 for RESET.
  - On mismatch, the pulse is retried, up to 3 retries.
  - RSP_ERR=1 if still failing; RSP_DATA carries the last CSA value.
- Undefined: RSP_ERR is tied 0 and no verify read occurs.

Decomposition:
- Package rram_ctrl_pkg holds:
  - op encoding (OP_READ/OP_SET/OP_RESET/OP_MAC);
  - state enum;
  - line-code constants LC_GND/LC_VREAD/LC_VPROG/LC_VHALF;
  - array width constants (16 rows, 16 cols).
- Sub-module rram_line_enc: maps a 16-bit select mask plus selected and unselected codes to the IN0/IN1 vector pair. It is instantiated three times (WL, BL, SL).

Test Plan:
- Reset asserted mid-ACT of SET -> all outputs 0 asynchronously, no RSP_VALID; CMD_READY=1 one cycle after release.
- READ row 3, CSA=16'hA5A5 during CAPT, defaults -> WL code 01 only on row 3, SAEN_CSA one cycle, RSP_VALID at cycle 9, RSP_DATA=16'hA5A5.
- SET row 5, mask 16'h0081 -> BL cols 0,7 = 10, others 11; WL row 5 = 10, others 11, for 4 cycles; RSP_VALID at cycle 7.
- MAC, mask 16'h000F, ADC_OUT0/1/2=16'h0011/16'h0022/16'h0033 -> CLK_EN_ADC 01/10 alternating for 8 cycles; RSP_ADC0/1/2 match the driven values.
- RSP_READY held low for 5 cycles -> RSP_VALID and data stable; CMD_READY stays 0; a CMD_VALID pulse is ignored.
- Back-to-back READ then RESET with RSP_READY=1 -> second accept on the cycle after the first response; no overlap of line codes.
